// File: rtl/word_serializer_32_pkg.sv
// rtl/word_serializer_32_pkg.sv - shared encodings and widths for the word serializer
package word_serializer_32_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int IDX_W          = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } ser_state_t;

endpackage

// File: rtl/word_serializer_32_byte_sel.sv
// rtl/word_serializer_32_byte_sel.sv - picks one byte of a word by index and byte order
module byte_sel_4to1
    import word_serializer_32_pkg::*;
(
    input  logic [WORD_W-1:0] din,
    input  logic [IDX_W-1:0]  idx,
    input  logic              msb_first,
    output logic [BYTE_W-1:0] dout
);

    logic [IDX_W-1:0] lane;

    // Index 0 maps to the top lane when sending most-significant byte first.
    always_comb begin
        lane = msb_first ? (IDX_W'(BYTES_PER_WORD - 1) - idx) : idx;
        dout = din[lane*BYTE_W +: BYTE_W];
    end

endmodule

// File: rtl/word_serializer_32.sv
// rtl/word_serializer_32.sv - loads a 32-bit word and streams it out one byte per handshake
module word_serializer_32
    import word_serializer_32_pkg::*;
#(
    parameter int MSB_FIRST = 1
) (
    input  logic                clk,
    input  logic                clear,
    input  logic [WORD_W-1:0]   D,
    input  logic                load,
    output logic                load_ready,
    input  logic                abort,
    output logic [BYTE_W-1:0]   byte_out,
    output logic                byte_valid,
    input  logic                byte_ready,
    output logic                busy,
    output logic                done
);

    ser_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] shadow_q, shadow_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    shadow_d = D;
                    idx_d    = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                // Abort wins over a handshake on the same edge.
                if (abort) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else if (byte_ready) begin
                    if (idx_q == IDX_W'(BYTES_PER_WORD - 1)) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
        end
    end

    assign load_ready = (state_q == ST_IDLE);
    assign byte_valid = (state_q == ST_SEND);
    assign busy       = (state_q == ST_SEND) || (state_q == ST_DONE);
    assign done       = (state_q == ST_DONE);

    byte_sel_4to1 u_byte_sel (
        .din       (shadow_q),
        .idx       (idx_q),
        .msb_first (MSB_FIRST != 0),
        .dout      (byte_out)
    );

endmodule

// File: tb/tb_word_serializer_32.sv
// tb/tb_word_serializer_32.sv - scoreboard bench for both byte orders of word_serializer_32
module tb_word_serializer_32;

    logic        clk = 1'b0;
    logic        clear, load, abort, byte_ready;
    logic [31:0] D;
    logic        lr_m, bv_m, busy_m, done_m, lr_l, bv_l, busy_l, done_l;
    logic [7:0]  bo_m, bo_l;

    logic [7:0]  q_m[$];
    logic [7:0]  q_l[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          done_cnt_m = 0;
    int          done_cnt_l = 0;
    int          exp_done = 0;

    always #5 clk = ~clk;

    word_serializer_32 #(.MSB_FIRST(1)) dut_m (
        .clk(clk), .clear(clear), .D(D), .load(load), .load_ready(lr_m),
        .abort(abort), .byte_out(bo_m), .byte_valid(bv_m), .byte_ready(byte_ready),
        .busy(busy_m), .done(done_m)
    );

    word_serializer_32 #(.MSB_FIRST(0)) dut_l (
        .clk(clk), .clear(clear), .D(D), .load(load), .load_ready(lr_l),
        .abort(abort), .byte_out(bo_l), .byte_valid(bv_l), .byte_ready(byte_ready),
        .busy(busy_l), .done(done_l)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Monitor: handshakes pop the scoreboard, stalls must hold the pending byte.
    always @(negedge clk) begin
        if (!clear) begin
            if (bv_m && byte_ready && !abort) begin
                if (q_m.size() == 0) chk("extra_byte_m", 32'(bo_m), 32'hFFFF);
                else chk("byte_m", 32'(bo_m), 32'(q_m.pop_front()));
            end else if (bv_m && !byte_ready && q_m.size() != 0) begin
                chk("hold_m", 32'(bo_m), 32'(q_m[0]));
            end
            if (bv_l && byte_ready && !abort) begin
                if (q_l.size() == 0) chk("extra_byte_l", 32'(bo_l), 32'hFFFF);
                else chk("byte_l", 32'(bo_l), 32'(q_l.pop_front()));
            end
            if (done_m) begin
                done_cnt_m++;
                chk("done_valid_m", 32'(bv_m), 32'd0);
                chk("done_q_empty_m", 32'(q_m.size()), 32'd0);
            end
            if (done_l) done_cnt_l++;
        end
    end

    task automatic send(input logic [31:0] w);
        for (int i = 0; i < 20 && !lr_m; i++) begin
            @(posedge clk); #1;
        end
        chk("load_ready_before_send", 32'(lr_m), 32'd1);
        D    = w;
        load = 1'b1;
        for (int b = 0; b < 4; b++) begin
            q_m.push_back(w[(3-b)*8 +: 8]);
            q_l.push_back(w[b*8 +: 8]);
        end
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        for (int i = 0; i < 80; i++) begin
            if (rnd) byte_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (done_m) break;
        end
        chk("done_seen", 32'(done_m), 32'd1);
        byte_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic flush();
        q_m.delete();
        q_l.delete();
    endtask

    initial begin
        clear = 1'b1; load = 1'b0; abort = 1'b0; byte_ready = 1'b1; D = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_load_ready", 32'(lr_m), 32'd1);
        chk("rst_valid", 32'(bv_m), 32'd0);
        chk("rst_busy", 32'(busy_m), 32'd0);
        chk("rst_done", 32'(done_m), 32'd0);
        chk("rst_byte_out", 32'(bo_m), 32'd0);
        clear = 1'b0;
        @(posedge clk); #1;

        // Back-to-back with exact cycle timing.
        send(32'hDEADBEEF);
        chk("first_valid", 32'(bv_m), 32'd1);
        chk("first_byte", 32'(bo_m), 32'hDE);
        chk("first_byte_l", 32'(bo_l), 32'hEF);
        repeat (4) @(posedge clk);
        #1;
        chk("done_timing", 32'(done_m), 32'd1);
        chk("done_busy", 32'(busy_m), 32'd1);
        chk("done_timing_l", 32'(done_l), 32'd1);
        exp_done++;
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done_m), 32'd0);
        chk("idle_after_done", 32'(lr_m), 32'd1);
        chk("idle_not_busy", 32'(busy_m), 32'd0);

        // Backpressure on the second byte.
        send(32'hDEADBEEF);
        @(posedge clk); #1;
        byte_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_byte", 32'(bo_m), 32'hAD);
        chk("stall_valid", 32'(bv_m), 32'd1);
        byte_ready = 1'b1;
        wait_done(1'b0);
        exp_done++;

        // Abort coincident with the second handshake.
        send(32'hDEADBEEF);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        flush();
        chk("abort_valid", 32'(bv_m), 32'd0);
        chk("abort_idle", 32'(lr_m), 32'd1);
        chk("abort_busy", 32'(busy_m), 32'd0);
        send(32'hCAFEF00D);
        chk("after_abort_first", 32'(bo_m), 32'hCA);
        wait_done(1'b0);
        exp_done++;

        // Load during SEND is ignored.
        send(32'hA5B6C7D8);
        D    = 32'h0;
        load = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        load = 1'b0;
        wait_done(1'b0);
        exp_done++;

        // Clear mid-transfer discards it.
        send(32'h01020304);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        flush();
        chk("clear_valid", 32'(bv_m), 32'd0);
        chk("clear_busy", 32'(busy_m), 32'd0);
        chk("clear_load_ready", 32'(lr_m), 32'd1);
        chk("clear_done", 32'(done_m), 32'd0);
        repeat (6) @(posedge clk);
        #1;

        // Random words under random backpressure.
        for (int k = 0; k < 6; k++) begin
            send($urandom);
            wait_done(1'b1);
            exp_done++;
        end

        repeat (4) @(posedge clk);
        #1;
        chk("done_count_m", 32'(done_cnt_m), 32'(exp_done));
        chk("done_count_l", 32'(done_cnt_l), 32'(exp_done));
        chk("queue_empty_m", 32'(q_m.size()), 32'd0);
        chk("queue_empty_l", 32'(q_l.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/word_serializer_32.md
WORD_SERIALIZER_32 -- requirements
Module: word_serializer_32

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 1, meaning byte order: 1 = bits [31:24] first, 0 = bits [7:0] first.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clear, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port D, input, 32 bits: parallel word to send.
REQ-005 The block SHALL have port load, input, 1 bit: capture D and start a transfer.
REQ-006 The block SHALL have port load_ready, output, 1 bit: block idle, load accepted this cycle.
REQ-007 The block SHALL have port abort, input, 1 bit: cancel the transfer in progress.
REQ-008 The block SHALL have port byte_out, output, 8 bits: current byte.
REQ-009 The block SHALL have port byte_valid, output, 1 bit: byte_out holds a valid byte.
REQ-010 The block SHALL have port byte_ready, input, 1 bit: consumer accepts byte_out this cycle.
REQ-011 The block SHALL have port busy, output, 1 bit: transfer in progress (state SEND or DONE).
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse after the 4th byte is accepted.

Function
REQ-013 The block SHALL implement the states IDLE, SEND and DONE.
REQ-014 In IDLE, load_ready SHALL be 1; load=1 SHALL capture D into an internal shadow register, set byte index 0 and enter SEND on the next edge.
REQ-015 Latency: load sampled at edge N SHALL give byte_valid=1 with the first byte in the cycle after edge N.
REQ-016 In SEND, byte_valid SHALL be 1; byte_out SHALL be shadow byte [index] in the order set by MSB_FIRST.
REQ-017 byte_out SHALL be held stable while byte_valid=1 and byte_ready=0, for any number of cycles.
REQ-018 A transfer SHALL occur only when byte_valid=1 and byte_ready=1 are sampled on the same edge; the index SHALL then increment.
REQ-019 A transfer at index 3 SHALL enter DONE; in DONE, done=1, byte_valid=0 and busy=1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-020 With byte_ready tied high, load at edge N SHALL give bytes in the cycles after edges N..N+3, done=1 in the cycle after N+4, and load_ready=1 in the cycle after N+5.
REQ-021 load while not in IDLE SHALL be ignored, and the shadow register SHALL NOT change.
REQ-022 Changes on D after capture SHALL NOT affect the bytes sent.
REQ-023 abort=1 in SEND SHALL force IDLE on the next edge with byte_valid=0, no done pulse, and no further byte transfer; the byte index SHALL wrap to 0.
REQ-024 If abort=1 and a byte handshake occur on the same edge, the abort SHALL take priority and the handshake SHALL NOT count as the 4th byte.
REQ-025 abort in IDLE or DONE SHALL have no effect.
REQ-026 The 2-bit byte index SHALL never wrap from 3 to 0 except by entering DONE or by abort.

Reset
REQ-027 clear=1 SHALL, on the next clk edge, set state IDLE, index 0, shadow 0, byte_valid 0, done 0, busy 0 and load_ready 1, overriding load and abort.
REQ-028 clear asserted mid-transfer SHALL discard the transfer with no done pulse.
REQ-029 All outputs SHALL be registered or decoded from registered state only, with no combinational path from byte_ready to byte_valid.

Structure
REQ-030 State encodings (IDLE=2'd0, SEND=2'd1, DONE=2'd2), BYTES_PER_WORD=4 and BYTE_W=8 SHALL live in the shared project package/header.
REQ-031 Byte selection SHALL be a sub-module byte_sel_4to1 (32-bit in, 2-bit index, order select, 8-bit out).
REQ-032 The FSM, index counter and shadow register SHALL be in word_serializer_32.

Verification
REQ-033 Reset: clear=1 mid-SEND -> next cycle byte_valid=0, busy=0, load_ready=1, no done pulse.
REQ-034 Back-to-back: MSB_FIRST=1, D=32'hDEADBEEF, byte_ready=1 -> byte_out DE, AD, BE, EF in consecutive cycles, then done=1 for one cycle.
REQ-035 Order: MSB_FIRST=0, D=32'h12345678 -> byte_out 78, 56, 34, 12.
REQ-036 Backpressure: byte_ready low for 3 cycles on the second byte -> byte_out held at AD with byte_valid=1; the sequence then completes unchanged.
REQ-037 Abort: abort=1 on the same edge as the 2nd-byte handshake -> IDLE, done never asserted; a new load of 32'hCAFEF00D then sends CA first.
REQ-038 Ignored load: load=1 with D=32'h0 during SEND -> the original word completes intact.
